// File: rtl/ro_harvest_ctrl.sv
// Harvest sequencer for the dual ring-oscillator entropy buffer: warm-up, timed byte capture, output FIFO.
// Optional repetition health check is compiled in when RO_HEALTH_CHECK_EN is defined.
module ro_harvest_ctrl #(
  parameter int WARMUP_CYCLES = 256,
  parameter int FIFO_DEPTH    = 4
`ifdef RO_HEALTH_CHECK_EN
  ,
  parameter int RPT_LIMIT     = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] num_bytes,
  input  logic [2:0] sel_cfg,
  output logic       ro_activate_1,
  output logic       ro_activate_2,
  output logic [2:0] out_sel,
  input  logic [7:0] byte_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       fault
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_SAMPLE, S_DRAIN} state_e;

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [9:0]    WARM_LAST = 10'(WARMUP_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = (AW)'(1);

  state_e        state_q, state_d;
  logic [9:0]    warm_q, warm_d;
  logic [6:0]    phase_q, phase_d;
  logic [7:0]    cap_cnt_q, cap_cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    num_q, num_d;
  logic [2:0]    out_sel_q, out_sel_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          take;
  logic          push;
  logic          pop;
`ifdef RO_HEALTH_CHECK_EN
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    rpt_q, rpt_d;
  logic [7:0]    rpt_next;
  logic          fault_q, fault_d;
`endif

  // NOTE: every _d signal takes its hold value before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    phase_d   = phase_q;
    cap_cnt_d = cap_cnt_q;
    sel_d     = sel_q;
    num_d     = num_q;
    out_sel_d = out_sel_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    take      = 1'b0;
`ifdef RO_HEALTH_CHECK_EN
    prev_d    = prev_q;
    rpt_d     = rpt_q;
    rpt_next  = rpt_q;
    fault_d   = fault_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d     = sel_cfg;
          num_d     = num_bytes;
          overrun_d = 1'b0;
          warm_d    = '0;
          cap_cnt_d = '0;
`ifdef RO_HEALTH_CHECK_EN
          fault_d   = 1'b0;
          rpt_d     = '0;
`endif
          state_d   = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (warm_q == WARM_LAST) begin
          state_d   = S_SAMPLE;
          out_sel_d = sel_q;
          // Countdown to the first capture: two oscillator stages, window fill and the buffer output register.
          phase_d   = {1'b0, sel_q, 3'b000} + 7'd11;
        end else begin
          warm_d = warm_q + 10'd1;
        end
      end
      S_SAMPLE: begin
        phase_d = phase_q - 7'd1;
        if (stop) state_d = S_DRAIN;
        if (phase_q == '0) begin
          phase_d = 7'd7;
`ifdef RO_HEALTH_CHECK_EN
          // rpt_q == 0 means no byte has been captured yet in this run.
          rpt_next = (rpt_q != '0 && byte_in == prev_q)
                   ? ((rpt_q == 8'hFF) ? rpt_q : rpt_q + 8'd1) : 8'd1;
          rpt_d    = rpt_next;
          prev_d   = byte_in;
          if (rpt_next >= 8'(RPT_LIMIT)) begin
            fault_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            take = 1'b1;
          end
`else
          take = 1'b1;
`endif
          if (take) begin
            cap_cnt_d = (cap_cnt_q == 8'hFF) ? cap_cnt_q : cap_cnt_q + 8'd1;
            if (num_q != '0 && cap_cnt_d == num_q) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a capture into a full FIFO still lands.
    pop  = (count_q != '0) && m_ready;
    push = take && ((count_q != CNT_FULL) || pop);
    if (take && !push) overrun_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  // The reset pin is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      warm_q    <= '0;
      phase_q   <= '0;
      cap_cnt_q <= '0;
      sel_q     <= '0;
      num_q     <= '0;
      out_sel_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef RO_HEALTH_CHECK_EN
      prev_q    <= '0;
      rpt_q     <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      phase_q   <= phase_d;
      cap_cnt_q <= cap_cnt_d;
      sel_q     <= sel_d;
      num_q     <= num_d;
      out_sel_q <= out_sel_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef RO_HEALTH_CHECK_EN
      prev_q    <= prev_d;
      rpt_q     <= rpt_d;
      fault_q   <= fault_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= byte_in;
  end

  assign ro_activate_1 = (state_q == S_WARMUP) || (state_q == S_SAMPLE);
  assign ro_activate_2 = ro_activate_1;
  assign out_sel       = out_sel_q;
  assign m_valid       = (count_q != '0);
  assign m_data        = m_valid ? mem[rd_ptr_q] : 8'h00;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign overrun       = overrun_q;
`ifdef RO_HEALTH_CHECK_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_ro_harvest_ctrl.sv
// Self-checking bench for ro_harvest_ctrl: behavioural queue model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_ro_harvest_ctrl;

  localparam int WARM  = 16;
  localparam int DEPTH = 4;
`ifdef RO_HEALTH_CHECK_EN
  localparam int RPT   = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, stop, m_ready;
  logic [7:0] num_bytes, byte_in;
  logic [2:0] sel_cfg;
  logic       ro_activate_1, ro_activate_2, m_valid, busy, done, overrun, fault;
  logic [2:0] out_sel;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  ro_harvest_ctrl #(.WARMUP_CYCLES(WARM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_bytes(num_bytes),
    .sel_cfg(sel_cfg), .ro_activate_1(ro_activate_1), .ro_activate_2(ro_activate_2),
    .out_sel(out_sel), .byte_in(byte_in), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .overrun(overrun), .fault(fault)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int byte_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_WARM, M_SAMPLE, M_DRAIN} mmode_e;
  mmode_e     md;
  int         md_cnt, md_p, md_sel, md_num, md_caps, md_outsel;
  bit         md_done, md_ovr, md_fault;
  logic [7:0] md_q[$];
`ifdef RO_HEALTH_CHECK_EN
  int         md_run;
  logic [7:0] md_prev;
`endif

  task automatic model_reset();
    md = M_IDLE; md_cnt = 0; md_p = 0; md_sel = 0; md_num = 0; md_caps = 0; md_outsel = 0;
    md_done = 0; md_ovr = 0; md_fault = 0;
    md_q.delete();
`ifdef RO_HEALTH_CHECK_EN
    md_run = 0; md_prev = 8'h00;
`endif
  endtask

  // Advances the model across the next rising edge using the inputs that edge will sample.
  task automatic model_step();
    bit pop, do_push, leave, faulted;
    int first;
    pop = (md_q.size() != 0) && m_ready;
    do_push = 0;
    md_done = 0;
    case (md)
      M_IDLE: if (start) begin
        md_sel = sel_cfg; md_num = num_bytes; md_ovr = 0; md_fault = 0;
        md_caps = 0; md_cnt = 0; md = M_WARM;
`ifdef RO_HEALTH_CHECK_EN
        md_run = 0;
`endif
      end
      M_WARM: if (stop) md = M_DRAIN;
              else begin
                md_cnt++;
                if (md_cnt == WARM) begin md = M_SAMPLE; md_p = 0; md_outsel = md_sel; end
              end
      M_SAMPLE: begin
        first = 8 * md_sel + 11;
        leave = stop;
        if (md_p >= first && (md_p - first) % 8 == 0) begin
          faulted = 0;
`ifdef RO_HEALTH_CHECK_EN
          md_run  = (md_run > 0 && byte_in == md_prev) ? md_run + 1 : 1;
          md_prev = byte_in;
          if (md_run >= RPT) begin md_fault = 1; faulted = 1; leave = 1; end
`endif
          if (!faulted) begin
            if (md_q.size() < DEPTH || pop) do_push = 1; else md_ovr = 1;
            if (md_caps < 255) md_caps++;
            if (md_num != 0 && md_caps == md_num) leave = 1;
          end
        end
        md_p++;
        if (leave) md = M_DRAIN;
      end
      M_DRAIN: if (md_q.size() == 0) begin md = M_IDLE; md_done = 1; end
      default: md = M_IDLE;
    endcase
    if (pop) void'(md_q.pop_front());
    if (do_push) md_q.push_back(byte_in);
  endtask

  // Single compare process: outputs reflect the last rising edge; inputs already hold next-edge values.
  always @(negedge clk) begin
    if (rst_n) model_reset();
    check("ro_activate_1", ro_activate_1, (md == M_WARM || md == M_SAMPLE));
    check("ro_activate_2", ro_activate_2, (md == M_WARM || md == M_SAMPLE));
    check("out_sel", out_sel, md_outsel);
    check("m_valid", m_valid, md_q.size() != 0);
    if (md_q.size() != 0) check("m_data", m_data, md_q[0]);
    check("busy", busy, md != M_IDLE);
    check("done", done, md_done);
    check("overrun", overrun, md_ovr);
    check("fault", fault, md_fault);
    if (!rst_n) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (byte_mode)
      0:       byte_in = 8'($urandom);
      1:       byte_in = 8'(cyc);
      2:       byte_in = 8'h00;
      default: byte_in = 8'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_run(input logic [2:0] sel, input logic [7:0] num);
    tick();
    start = 1'b1; sel_cfg = sel; num_bytes = num;
    tick();
    start = 1'b0;
    sel_cfg = 3'($urandom); num_bytes = 8'($urandom);
  endtask

  task automatic wait_done(input int max_cyc, input int stop_at, input bit rnd_ready,
                           output int delivered);
    bit seen;
    seen = 0;
    delivered = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) delivered++;
      if (done) seen = 1;
      tick();
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
      stop  = (i + 1 == stop_at);
      start = !seen && ($urandom_range(0, 15) == 0);
    end
    stop = 1'b0; start = 1'b0;
    check("done_within_budget", seen, 1);
  endtask

  task automatic wait_drain(input int max_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (busy && !ro_activate_1) seen = 1; else tick();
    end
    check("reach_drain", seen, 1);
  endtask

  initial begin
    int d, c0, first_v, done_n, done_cnt, stop_at;
    bit act_n0, act_n60, busy_n60, busy_n62;
    int vn[$];
    logic [7:0] vd[$];

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_bytes = '0; sel_cfg = '0;
    byte_in = '0; m_ready = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 8'h00);

    // Directed timing: sel=2, num=3, continuous accept, byte_in tracks the edge count.
    byte_mode = 1; m_ready = 1'b1;
    tick();
    start = 1'b1; sel_cfg = 3'd2; num_bytes = 8'd3;
    tick();
    c0 = cyc; start = 1'b0;
    first_v = -1; done_n = -1; done_cnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (m_valid) begin
        if (first_v < 0) first_v = n;
        vn.push_back(n); vd.push_back(m_data);
      end
      if (done) begin done_n = n; done_cnt++; end
      if (n == 0)  act_n0 = ro_activate_1;
      if (n == 60) begin act_n60 = ro_activate_1; busy_n60 = busy; end
      if (n == 62) busy_n62 = busy;
      tick();
      start = (n + 1 == 4);
    end
    start = 1'b0;
    check("t2_activate_after_start", act_n0, 1);
    check("t2_first_valid_cycle", first_v, 44);
    check("t2_bytes_delivered", vn.size(), 3);
    if (vn.size() == 3) begin
      check("t2_push1_cycle", vn[0], 44);
      check("t2_push2_cycle", vn[1], 52);
      check("t2_push3_cycle", vn[2], 60);
      check("t2_byte1", vd[0], 8'(c0 + 43));
      check("t2_byte3", vd[2], 8'(c0 + 59));
    end
    check("t2_activate_in_drain", act_n60, 0);
    check("t2_busy_in_drain", busy_n60, 1);
    check("t2_done_cycle", done_n, 62);
    check("t2_done_count", done_cnt, 1);
    check("t2_idle_after_done", busy_n62, 0);

    // Overflow: six captures into a 4-deep FIFO with no consumer.
    byte_mode = 0; m_ready = 1'b0;
    start_run(3'd0, 8'd6);
    wait_drain(200);
    check("t3_overrun", overrun, 1);
    check("t3_fifo_held", m_valid, 1);
    tick();
    m_ready = 1'b1;
    wait_done(100, -1, 0, d);
    check("t3_delivered", d, 4);

    // Early stop in continuous mode 50 cycles into SAMPLE.
    start_run(3'd0, 8'd0);
    wait_done(300, WARM + 50, 0, d);
    check("t4_delivered", d, 5);

    // Stop during warm-up.
    start_run(3'd5, 8'd4);
    wait_done(100, 7, 0, d);
    check("t5_delivered", d, 0);

    // Constant input: health check trips on the 4th capture when built in.
    byte_mode = 2;
    start_run(3'd1, 8'd6);
    wait_done(400, -1, 0, d);
`ifdef RO_HEALTH_CHECK_EN
    check("t6_delivered", d, 3);
    check("t6_fault", fault, 1);
`else
    check("t6_delivered", d, 6);
    check("t6_fault", fault, 0);
`endif

    // Reset during SAMPLE with bytes queued.
    byte_mode = 0; m_ready = 1'b0;
    start_run(3'd1, 8'd0);
    repeat (50) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_busy", busy, 0);
    check("t1_m_valid", m_valid, 0);
    check("t1_activate", ro_activate_1, 0);
    check("t1_out_sel", out_sel, 0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_no_done", done, 0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      byte_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      m_ready = 1'b1;
      num_bytes = 8'($urandom_range(0, 9));
      stop_at = (num_bytes == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(5, 150)) : -1;
      start_run(3'($urandom), num_bytes);
      wait_done(2000, stop_at, 1, d);
    end

    // Long continuous run past capture-count saturation.
    byte_mode = 0; m_ready = 1'b1;
    start_run(3'd7, 8'd0);
    wait_done(2600, 2300, 0, d);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
